chan_packetizer: RTL
====================

# chan_packetizer

Downstream stage of the channel down-selector in the M2 channelizer. Consumes the down-selected sample stream (tuser carries channel/time, input tlast marks end of a frame of selected channels, eob marks end of burst). Re-frames it into output packets of exactly `packet_length` words, with tlast and an EOB flag on the final word. Presents the packets on a registered AXI-Stream master ready for the RFNoC framer.

## Interface
- DATA_WIDTH, 32, width of s/m tdata
- TUSER_WIDTH, 24, width of s/m tuser
- clk  in  1  single clock; all logic rising-edge
- sync_reset_n  in  1  reset, asynchronous, active-low
- packet_length  in  16  payload words per output packet; sampled at packet start
- s_axis_tvalid  in  1  input word valid
- s_axis_tdata  in  DATA_WIDTH  selected sample
- s_axis_tuser  in  TUSER_WIDTH  channel/time tag of the sample
- s_axis_tlast  in  1  last selected word of a channelizer frame
- eob_in  in  1  end-of-burst; qualified only with an accepted word
- s_axis_tready  out  1  input accept
- m_axis_tvalid  out  1  output word valid
- m_axis_tdata  out  DATA_WIDTH  sample
- m_axis_tuser  out  TUSER_WIDTH  tuser of the packet's first word, held for the whole packet
- m_axis_tlast  out  1  last word of packet
- m_axis_eob  out  1  packet closed by EOB; valid with tlast
- m_axis_tready  in  1  downstream accept
- pkt_count  out  32  packets emitted since reset, wraps at 2^32

## Operation
- Accept: take = s_axis_tvalid & s_axis_tready. s_axis_tready = skid buffer not full (entry count < 2).
- State machine, 2 states:
  - S_IDLE: no packet open. On take: latch len_reg = max(packet_length, 1), latch sop_tuser = s_axis_tuser, word_cnt = 1, go to S_FILL. If this word also closes the packet, stay in S_IDLE.
  - S_FILL: on take: word_cnt += 1. The packet closes on this word if word_cnt == len_reg, or if eob_in == 1. Closing returns to S_IDLE and clears word_cnt to 0.
- A closing word is pushed with tlast = 1 and eob = eob_in.
- A word in S_IDLE with len_reg = 1 closes immediately, so single-word packets are legal.
- Input s_axis_tlast does not close packets. It is ignored except for the frame_err check.
- Frame check: frame_err is an internal sticky flag, exposed only in simulation. It sets if an EOB-closed packet ends on a word without s_axis_tlast. The sticky flag is cleared only by reset.
- Pushed word = {tdata, sop_tuser (or the live tuser for the first word), tlast, eob}. It goes into a 2-entry skid buffer; the output is driven from the buffer head.
- pkt_count increments when a word with tlast = 1 is accepted at the output (m_axis_tvalid & m_axis_tready & m_axis_tlast).
- packet_length changes mid-packet have no effect until the next packet start.
- word_cnt is 16 bits. len_reg of 65535 is reached without overflow.

## Timing
- Reset (async assert, sync deassert in the reset tree): S_IDLE, word_cnt = 0, len_reg = 1, sop_tuser = 0, skid buffer empty. Outputs: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0, m_axis_eob = 0, pkt_count = 0, s_axis_tready = 0 during reset and 1 on the first cycle after release.
- Latency: a word accepted in cycle N is on m_axis in cycle N+1 if the buffer was empty.
- Throughput is one word per cycle with m_axis_tready held high.
- All m_axis outputs come directly from flops.
- Buffer full with a simultaneous pop: s_axis_tready stays 0 that cycle (registered ready). Ready returns the next cycle; no word is lost or duplicated.
- Simultaneous push and pop on a 1-entry buffer: the count stays 1 and the head advances.
- AXI rule: once m_axis_tvalid is 1 it holds with stable data until m_axis_tready.
- Reset mid-packet: the partial packet is discarded and the buffer is flushed. The first word after reset starts a new packet.

## Structure
- Shared package chan_pkt_pkg holds:
  - state encoding S_IDLE = 0, S_FILL = 1;
  - the skid entry width constant (DATA_WIDTH + TUSER_WIDTH + 2).
- One sub-module, axi_skid_2: a generic 2-entry registered buffer with payload width as a parameter and valid/ready on both sides.
- Top level contains the FSM, counters and tuser latch.

## Test plan
- packet_length = 4, 12 continuous words with m_axis_tready = 1 -> 3 packets; tlast on output words 4, 8 and 12; m_axis_tuser equals the tuser of words 1, 5 and 9 respectively; pkt_count = 3.
- packet_length = 4, eob_in pulsed with word 6 -> packets of 4 and 2 words; second packet has tlast = 1, eob = 1; next word starts a new 4-word packet.
- packet_length = 0 then 1, 3 words each -> every word is a 1-word packet with tlast = 1; pkt_count = 6.
- Random m_axis_tready (50%), 1000 words, packet_length = 7 -> output data sequence identical to input; tlast every 7th word; no tvalid drop while tready is low.
- packet_length changed from 8 to 3 after word 2 of a packet -> that packet is still 8 words; the following packets are 3 words.
- sync_reset_n asserted after word 3 of a 5-word packet -> all outputs at reset values immediately; after release, words restart with word_cnt = 1 and the first tlast is on the 5th new word.

Source files
------------

// File: rtl/chan_pkt_pkg.sv
// Shared types and sizing helpers for the channel packetizer and its output buffer.
package chan_pkt_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } pkt_state_e;

    // Skid entry layout is {tdata, tuser, tlast, eob}.
    function automatic int unsigned skid_entry_width(input int unsigned dw, input int unsigned tw);
        return dw + tw + 2;
    endfunction

    localparam int unsigned SKID_ENTRY_W = skid_entry_width(32, 24);

endpackage

// File: rtl/axi_skid_2.sv
// Generic 2-entry registered valid/ready buffer; output payload and valid come straight from flops.
module axi_skid_2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             valid_q, ready_q;
    logic             push, pop;

    always_comb begin
        push   = in_valid & ready_q;
        pop    = valid_q & out_ready;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = in_data;
                else               tail_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_data;
                end else begin
                    head_d = in_data;
                end
            end
            default: ;
        endcase
    end

    // Ready is registered from the next count, so a full buffer stays closed during its pop cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (cnt_d != 2'd0);
            ready_q <= (cnt_d < 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/chan_packetizer.sv
// Re-frames the down-selected sample stream into fixed-length packets with tlast/EOB,
// presented through a registered 2-entry AXI-Stream output buffer.
import chan_pkt_pkg::*;

module chan_packetizer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TUSER_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   sync_reset_n,
    input  logic [15:0]            packet_length,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   eob_in,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic                   m_axis_eob,
    input  logic                   m_axis_tready,
    output logic [31:0]            pkt_count
);

    localparam int unsigned ENTRY_W = skid_entry_width(DATA_WIDTH, TUSER_WIDTH);

    pkt_state_e             state_q, state_d;
    logic [15:0]            word_cnt_q, word_cnt_d, len_q, len_d, len_start, cnt_inc;
    logic [TUSER_WIDTH-1:0] sop_tuser_q, sop_tuser_d, tuser_push;
    logic [31:0]            pkt_count_q, pkt_count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   take, close;
    logic [ENTRY_W-1:0]     push_entry, head_entry;

    always_comb begin
        take        = s_axis_tvalid & s_axis_tready;
        len_start   = (packet_length == '0) ? 16'd1 : packet_length;
        cnt_inc     = word_cnt_q + 16'd1;
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        sop_tuser_d = sop_tuser_q;
        tuser_push  = sop_tuser_q;
        close       = 1'b0;
        if (take) begin
            unique case (state_q)
                S_IDLE: begin
                    len_d       = len_start;
                    sop_tuser_d = s_axis_tuser;
                    tuser_push  = s_axis_tuser;
                    close       = (len_start == 16'd1) | eob_in;
                    word_cnt_d  = close ? 16'd0 : 16'd1;
                    state_d     = close ? S_IDLE : S_FILL;
                end
                S_FILL: begin
                    close      = (cnt_inc == len_q) | eob_in;
                    word_cnt_d = close ? 16'd0 : cnt_inc;
                    state_d    = close ? S_IDLE : S_FILL;
                end
                default: ;
            endcase
        end
        frame_err_d = frame_err_q | (take & close & eob_in & ~s_axis_tlast);
        pkt_count_d = pkt_count_q;
        if (m_axis_tvalid & m_axis_tready & m_axis_tlast) pkt_count_d = pkt_count_q + 32'd1;
        push_entry = {s_axis_tdata, tuser_push, close, close & eob_in};
    end

    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            len_q       <= 16'd1;
            sop_tuser_q <= '0;
            pkt_count_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            sop_tuser_q <= sop_tuser_d;
            pkt_count_q <= pkt_count_d;
            frame_err_q <= frame_err_d;
        end
    end

    axi_skid_2 #(.WIDTH(ENTRY_W)) u_skid (
        .clk       (clk),
        .rst_n     (sync_reset_n),
        .in_valid  (s_axis_tvalid),
        .in_data   (push_entry),
        .in_ready  (s_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_data  (head_entry),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_eob} = head_entry;
    assign pkt_count = pkt_count_q;

endmodule
